// File: rtl/pipeline_pkg.sv
// Shared types for the decode/execute boundary: forward-source encoding, operand indices,
// the control-flag bundle carried into execute and the stall FSM states.
package pipeline_pkg;

  typedef enum logic [1:0] {
    DECODE_RF_OPERAND      = 2'd0,
    MEM_ACCESS_DM_OPERAND  = 2'd1,
    EXECUTE_ALU_OPERAND    = 2'd2,
    MEM_ACCESS_ALU_OPERAND = 2'd3
  } forward_sel_e;

  localparam int unsigned OPERAND_A = 0;
  localparam int unsigned OPERAND_B = 1;

  typedef struct packed {
    logic valid;
    logic rf_write_enable;
    logic dm_read_enable;
    logic dm_write_enable;
  } d_to_e_bundle_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStall1 = 2'd1,
    StErr    = 2'd2
  } stall_state_e;

  // True when either operand takes a bypass path instead of the register file.
  function automatic logic any_forward(input logic [1:0][1:0] sel);
    return (sel[OPERAND_A] != DECODE_RF_OPERAND) || (sel[OPERAND_B] != DECODE_RF_OPERAND);
  endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// 4:1 operand source select: register file or one of the three bypass paths.
module operand_forward_mux
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  forward_sel_e          i_sel,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  input  logic [DATA_WIDTH-1:0] i_mem_dm_data,
  input  logic [DATA_WIDTH-1:0] i_ex_alu_data,
  input  logic [DATA_WIDTH-1:0] i_mem_alu_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_rf_data;
    unique case (i_sel)
      DECODE_RF_OPERAND:      o_data = i_rf_data;
      MEM_ACCESS_DM_OPERAND:  o_data = i_mem_dm_data;
      EXECUTE_ALU_OPERAND:    o_data = i_ex_alu_data;
      MEM_ACCESS_ALU_OPERAND: o_data = i_mem_alu_data;
    endcase
  end

endmodule

// File: rtl/decode_execute_forward_stage.sv
// Decode-to-execute pipeline register with operand forwarding, bubble injection on
// stall/flush, saturating hazard statistics and a sticky stall-protocol error flag.
module decode_execute_forward_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REGISTER_SIZE = 5,
  parameter int unsigned CTRL_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_to_d_enable_ff,
  input  logic                     d_to_e_enable_ff,
  input  logic [1:0][1:0]          pipeline_forward_sel,
  input  logic                     flush,
  input  logic                     d_valid,
  input  logic [DATA_WIDTH-1:0]    d_rf_data_a,
  input  logic [DATA_WIDTH-1:0]    d_rf_data_b,
  input  logic [REGISTER_SIZE-1:0] d_destination_reg,
  input  logic                     d_rf_write_enable,
  input  logic                     d_dm_read_enable,
  input  logic                     d_dm_write_enable,
  input  logic [CTRL_WIDTH-1:0]    d_ctrl,
  input  logic [DATA_WIDTH-1:0]    ex_alu_data,
  input  logic [DATA_WIDTH-1:0]    mem_alu_data,
  input  logic [DATA_WIDTH-1:0]    mem_dm_data,
  output logic                     e_valid,
  output logic [DATA_WIDTH-1:0]    e_operand_a,
  output logic [DATA_WIDTH-1:0]    e_operand_b,
  output logic [REGISTER_SIZE-1:0] e_destination_reg,
  output logic                     e_rf_write_enable,
  output logic                     e_dm_read_enable,
  output logic                     e_dm_write_enable,
  output logic [CTRL_WIDTH-1:0]    e_ctrl,
  output logic [CNT_WIDTH-1:0]     stall_count,
  output logic [CNT_WIDTH-1:0]     forward_count,
  output logic                     stall_error
);

  logic [DATA_WIDTH-1:0]    w_operand_a;
  logic [DATA_WIDTH-1:0]    w_operand_b;
  logic                     w_stall;
  logic                     w_launch;
  logic                     w_fwd_launch;
  d_to_e_bundle_t           w_bundle;

  d_to_e_bundle_t           r_bundle;
  logic [DATA_WIDTH-1:0]    r_operand_a;
  logic [DATA_WIDTH-1:0]    r_operand_b;
  logic [REGISTER_SIZE-1:0] r_destination_reg;
  logic [CTRL_WIDTH-1:0]    r_ctrl;
  logic [CNT_WIDTH-1:0]     r_stall_count;
  logic [CNT_WIDTH-1:0]     r_forward_count;
  logic                     r_stall_error;
  stall_state_e             r_state;

  operand_forward_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux_a (
    .i_sel         (forward_sel_e'(pipeline_forward_sel[OPERAND_A])),
    .i_rf_data     (d_rf_data_a),
    .i_mem_dm_data (mem_dm_data),
    .i_ex_alu_data (ex_alu_data),
    .i_mem_alu_data(mem_alu_data),
    .o_data        (w_operand_a)
  );

  operand_forward_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux_b (
    .i_sel         (forward_sel_e'(pipeline_forward_sel[OPERAND_B])),
    .i_rf_data     (d_rf_data_b),
    .i_mem_dm_data (mem_dm_data),
    .i_ex_alu_data (ex_alu_data),
    .i_mem_alu_data(mem_alu_data),
    .o_data        (w_operand_b)
  );

  // Flush outranks stall, so a flushed stall cycle is not counted as a stall bubble.
  assign w_stall      = !d_to_e_enable_ff && !flush;
  assign w_launch     = d_to_e_enable_ff && !flush;
  assign w_fwd_launch = w_launch && d_valid && any_forward(pipeline_forward_sel);

  always_comb begin
    w_bundle                 = '0;
    w_bundle.valid           = d_valid;
    w_bundle.rf_write_enable = d_rf_write_enable && d_valid;
    w_bundle.dm_read_enable  = d_dm_read_enable && d_valid;
    w_bundle.dm_write_enable = d_dm_write_enable && d_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bundle          <= '0;
      r_operand_a       <= '0;
      r_operand_b       <= '0;
      r_destination_reg <= '0;
      r_ctrl            <= '0;
    end else if (w_launch) begin
      r_bundle          <= w_bundle;
      r_operand_a       <= w_operand_a;
      r_operand_b       <= w_operand_b;
      r_destination_reg <= d_destination_reg;
      r_ctrl            <= d_ctrl;
    end else begin
      r_bundle          <= '0;
      r_operand_a       <= '0;
      r_operand_b       <= '0;
      r_destination_reg <= '0;
      r_ctrl            <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count   <= '0;
      r_forward_count <= '0;
    end else begin
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
      if (w_fwd_launch && (r_forward_count != '1)) begin
        r_forward_count <= r_forward_count + 1'b1;
      end
    end
  end

  // Load-use needs exactly one bubble; a second consecutive stall is a protocol error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_stall_error <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_stall) r_state <= StStall1;
        end
        StStall1: begin
          if (w_stall) begin
            r_state       <= StErr;
            r_stall_error <= 1'b1;
          end else begin
            r_state <= StIdle;
          end
        end
        StErr: begin
          if (!w_stall) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
      // Bubbling execute while decode advances would drop the decode instruction.
      if (w_stall && f_to_d_enable_ff) r_stall_error <= 1'b1;
    end
  end

  assign e_valid           = r_bundle.valid;
  assign e_rf_write_enable = r_bundle.rf_write_enable;
  assign e_dm_read_enable  = r_bundle.dm_read_enable;
  assign e_dm_write_enable = r_bundle.dm_write_enable;
  assign e_operand_a       = r_operand_a;
  assign e_operand_b       = r_operand_b;
  assign e_destination_reg = r_destination_reg;
  assign e_ctrl            = r_ctrl;
  assign stall_count       = r_stall_count;
  assign forward_count     = r_forward_count;
  assign stall_error       = r_stall_error;

endmodule
